mcpu_ctrl_fsm: RTL and testbench
================================

// Module: mcpu_ctrl_fsm
// PURPOSE
//  Multi-cycle MIPS control unit; successor to the single-cycle decoder. Sequences IF/ID/EX/MEM/WB per
//  instruction from the IR-held OPcode/Fun, stalls on MIO_ready at every memory access, flags timeouts and
//  illegal opcodes. Sits between the IR and the multi-cycle datapath (PC, IR, MDR, A/B, ALUOut).
// PARAMETERS
//  ALUC_W       3   ALU_Control width; codes 000 and,001 or,010 add,110 sub,111 slt,100 nor,011 xor,101 srl; upper bits 0 if >3
//  MIO_TIMEOUT  16  max consecutive wait cycles in a memory state before ERR; 0 disables timeout
//  EN_IMM       1   1: addi/andi/ori/slti/lui decoded; 0: these are illegal
//  EN_BNE       1   1: bne decoded; 0: illegal
// PORTS
//  clk          in   1       clock, rising edge
//  rst          in   1       asynchronous, active-high reset
//  OPcode       in   6       IR[31:26], stable from ID onward
//  Fun          in   6       IR[5:0]
//  zero         in   1       ALU zero flag (for branches)
//  MIO_ready    in   1       memory/IO access complete this cycle
//  PCWrite      out  1       unconditional PC load
//  PCWriteCond  out  1       PC load if (zero ^ Branch_ne)
//  Branch_ne    out  1       1 during bne EX
//  IorD         out  1       0 PC addr, 1 ALUOut addr
//  mem_r/mem_w  out  1/1     memory read/write strobe
//  IRWrite      out  1       IR load
//  RegDst       out  2       00 rt, 01 rd, 10 $31
//  MemtoReg     out  2       00 ALUOut, 01 MDR, 10 PC, 11 {imm,16'h0}
//  ALUSrcA      out  1       0 PC, 1 A
//  ALUSrcB      out  2       00 B, 01 4, 10 ext imm, 11 sext imm<<2
//  SignExt      out  1       1 sign-extend imm, 0 zero-extend (andi/ori)
//  PCSource     out  2       00 ALU, 01 ALUOut, 10 jump target
//  RegWrite     out  1       register-file write
//  ALU_Control  out  ALUC_W  ALU op
//  CPU_MIO      out  1       1 while a memory access is pending
//  state        out  4       current state (debug)
//  err          out  1       sticky error
// BEHAVIOUR
//  States: IDLE=0 IF=1 ID=2 EX_R=3 EX_I=4 MEM_ADR=5 MEM_RD=6 MEM_WR=7 WB_R=8 WB_I=9 WB_LW=10 EX_BR=11 EX_J=12 ERR=15.
//  Reset: state=IDLE, wait counter=0, err=0; all outputs decoded 0. IDLE->IF unconditionally next edge.
//  Outputs are Moore, combinational from state (+OPcode/Fun in EX/WB); no output is asserted in IDLE/ERR.
//  IF: IorD=0,mem_r=1,CPU_MIO=1,ALUSrcA=0,ALUSrcB=01,add,PCSource=00. IRWrite and PCWrite assert only in the
//   cycle MIO_ready=1; then ->ID. Otherwise hold.
//  ID: ALUSrcA=0,ALUSrcB=11,add (branch target to ALUOut). Decode: R-type(000000) ->EX_R; lw/sw ->MEM_ADR;
//   beq/bne ->EX_BR; j/jal ->EX_J; imm ops ->EX_I; anything else (incl. disabled by params, unknown Fun) ->ERR.
//  EX_R: ALUSrcA=1,ALUSrcB=00, ALU op from Fun (20 add,22 sub,24 and,25 or,2A slt,27 nor,26 xor,02 srl) ->WB_R.
//  WB_R: RegDst=01,MemtoReg=00,RegWrite=1 ->IF.   EX_I: ALUSrcA=1,ALUSrcB=10, op per opcode ->WB_I.
//  WB_I: RegDst=00,RegWrite=1, MemtoReg=11 for lui else 00 ->IF.
//  MEM_ADR: ALUSrcA=1,ALUSrcB=10,SignExt=1,add; lw->MEM_RD, sw->MEM_WR.
//  MEM_RD/MEM_WR: IorD=1,CPU_MIO=1, mem_r resp. mem_w held; leave on MIO_ready: MEM_RD->WB_LW, MEM_WR->IF.
//  WB_LW: RegDst=00,MemtoReg=01,RegWrite=1 ->IF.
//  EX_BR: ALUSrcA=1,ALUSrcB=00,sub,PCSource=01,PCWriteCond=1,Branch_ne=(bne) ->IF.
//  EX_J: PCSource=10,PCWrite=1; jal also RegDst=10,MemtoReg=10,RegWrite=1 ->IF.
//  Cycle counts with MIO_ready tied 1: R/imm 4, lw 5, sw 4, beq/bne/j/jal 3.
//  Wait counter: clears on entering IF/MEM_RD/MEM_WR and on MIO_ready; increments per stalled cycle; when it
//   reaches MIO_TIMEOUT with MIO_ready=0 ->ERR. MIO_ready on the same cycle wins over timeout.
//  ERR: absorbing; err=1 until rst. rst asserted mid-instruction aborts immediately to IDLE, no partial write.
// TESTING
//  rst=1 then release, MIO_ready=1, OPcode=0 Fun=20 -> states 0,1,2,3,8,1; RegWrite=1 only in WB_R, ALU_Control=010 in EX_R.
//  lw (23) with MIO_ready low 3 cycles in MEM_RD -> holds state 6 for 3 extra cycles, mem_r held, then WB_LW MemtoReg=01.
//  beq(04) zero=1 -> EX_BR PCWriteCond=1 Branch_ne=0; bne(05) -> Branch_ne=1; EN_BNE=0 bne -> ERR, err=1.
//  jal(03) -> EX_J PCWrite=1,RegDst=10,MemtoReg=10,RegWrite=1, then IF; lui(0F) -> WB_I MemtoReg=11.
//  MIO_ready=0 for 16 cycles in IF (MIO_TIMEOUT=16) -> ERR, err sticky; ready on cycle 16 -> ID, no err.
//  rst pulsed during MEM_WR -> async to IDLE, mem_w=0 same cycle; OPcode=3F -> ERR from ID.

Source files
------------

// File: rtl/mcpu_ctrl_if.sv
// Control bundle between the multi-cycle MIPS control FSM (master) and the datapath (slave).
interface mcpu_ctrl_if #(
  parameter int unsigned ALUC_W = 3
);
  logic [5:0]        OPcode;
  logic [5:0]        Fun;
  logic              zero;
  logic              MIO_ready;
  logic              PCWrite;
  logic              PCWriteCond;
  logic              Branch_ne;
  logic              IorD;
  logic              mem_r;
  logic              mem_w;
  logic              IRWrite;
  logic [1:0]        RegDst;
  logic [1:0]        MemtoReg;
  logic              ALUSrcA;
  logic [1:0]        ALUSrcB;
  logic              SignExt;
  logic [1:0]        PCSource;
  logic              RegWrite;
  logic [ALUC_W-1:0] ALU_Control;
  logic              CPU_MIO;
  logic [3:0]        state;
  logic              err;

  modport master (
    input  OPcode, Fun, zero, MIO_ready,
    output PCWrite, PCWriteCond, Branch_ne, IorD, mem_r, mem_w, IRWrite, RegDst, MemtoReg,
           ALUSrcA, ALUSrcB, SignExt, PCSource, RegWrite, ALU_Control, CPU_MIO, state, err
  );

  modport slave (
    output OPcode, Fun, zero, MIO_ready,
    input  PCWrite, PCWriteCond, Branch_ne, IorD, mem_r, mem_w, IRWrite, RegDst, MemtoReg,
           ALUSrcA, ALUSrcB, SignExt, PCSource, RegWrite, ALU_Control, CPU_MIO, state, err
  );
endinterface

// File: rtl/mcpu_ctrl_fsm.sv
// Multi-cycle MIPS control FSM: sequences IF/ID/EX/MEM/WB, stalls on MIO_ready,
// flags memory timeouts and illegal instructions with a sticky err.
module mcpu_ctrl_fsm #(
  parameter int unsigned ALUC_W      = 3,
  parameter int unsigned MIO_TIMEOUT = 16,
  parameter bit          EN_IMM      = 1'b1,
  parameter bit          EN_BNE      = 1'b1
) (
  input logic         clk,
  input logic         rst,
  mcpu_ctrl_if.master bus
);
  typedef enum logic [3:0] {
    StIdle   = 4'd0,  StIf    = 4'd1,  StId  = 4'd2,  StExR  = 4'd3,
    StExI    = 4'd4,  StMemAdr = 4'd5, StMemRd = 4'd6, StMemWr = 4'd7,
    StWbR    = 4'd8,  StWbI   = 4'd9,  StWbLw = 4'd10, StExBr = 4'd11,
    StExJ    = 4'd12, StErr   = 4'd15
  } state_e;

  localparam logic [5:0] OpR = 6'h00, OpJ = 6'h02, OpJal = 6'h03, OpBeq = 6'h04;
  localparam logic [5:0] OpBne = 6'h05, OpAddi = 6'h08, OpSlti = 6'h0A, OpAndi = 6'h0C;
  localparam logic [5:0] OpOri = 6'h0D, OpLui = 6'h0F, OpLw = 6'h23, OpSw = 6'h2B;

  localparam logic [2:0] AluAnd = 3'b000, AluOr = 3'b001, AluAdd = 3'b010, AluXor = 3'b011;
  localparam logic [2:0] AluNor = 3'b100, AluSrl = 3'b101, AluSub = 3'b110, AluSlt = 3'b111;

  localparam int unsigned CntW = (MIO_TIMEOUT > 1) ? $clog2(MIO_TIMEOUT + 1) : 1;
  localparam logic [CntW:0] TimeoutVal = MIO_TIMEOUT[CntW:0];

  state_e          state_q;
  logic [CntW-1:0] wait_q;
  logic            err_q;
  logic [CntW:0]   wait_inc;
  logic            timeout_hit;
  state_e          id_next;
  logic [2:0]      r_op;
  logic            r_valid;
  logic [2:0]      i_op;
  logic [2:0]      alu_op;
  logic            unused_zero;

  // Branch resolution happens in the datapath via PCWriteCond.
  assign unused_zero = bus.zero;

  always_comb begin
    r_valid = 1'b1;
    r_op    = AluAdd;
    case (bus.Fun)
      6'h20:   r_op = AluAdd;
      6'h22:   r_op = AluSub;
      6'h24:   r_op = AluAnd;
      6'h25:   r_op = AluOr;
      6'h2A:   r_op = AluSlt;
      6'h27:   r_op = AluNor;
      6'h26:   r_op = AluXor;
      6'h02:   r_op = AluSrl;
      default: r_valid = 1'b0;
    endcase
  end

  always_comb begin
    case (bus.OPcode)
      OpSlti:  i_op = AluSlt;
      OpAndi:  i_op = AluAnd;
      OpOri:   i_op = AluOr;
      default: i_op = AluAdd;
    endcase
  end

  always_comb begin
    case (bus.OPcode)
      OpR:                                  id_next = r_valid ? StExR : StErr;
      OpLw, OpSw:                           id_next = StMemAdr;
      OpBeq:                                id_next = StExBr;
      OpBne:                                id_next = EN_BNE ? StExBr : StErr;
      OpJ, OpJal:                           id_next = StExJ;
      OpAddi, OpSlti, OpAndi, OpOri, OpLui: id_next = EN_IMM ? StExI : StErr;
      default:                              id_next = StErr;
    endcase
  end

  assign wait_inc    = {1'b0, wait_q} + {{CntW{1'b0}}, 1'b1};
  assign timeout_hit = (MIO_TIMEOUT != 0) && !bus.MIO_ready && (wait_inc == TimeoutVal);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      wait_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      wait_q <= '0;
      case (state_q)
        StIdle: state_q <= StIf;
        StIf, StMemRd, StMemWr: begin
          // A ready on the timeout cycle still completes the access.
          if (bus.MIO_ready) begin
            if (state_q == StIf)         state_q <= StId;
            else if (state_q == StMemRd) state_q <= StWbLw;
            else                         state_q <= StIf;
          end else if (timeout_hit) begin
            state_q <= StErr;
            err_q   <= 1'b1;
          end else begin
            wait_q <= wait_inc[CntW-1:0];
          end
        end
        StId: begin
          state_q <= id_next;
          if (id_next == StErr) err_q <= 1'b1;
        end
        StExR:    state_q <= StWbR;
        StExI:    state_q <= StWbI;
        StMemAdr: state_q <= (bus.OPcode == OpLw) ? StMemRd : StMemWr;
        StWbR, StWbI, StWbLw, StExBr, StExJ: state_q <= StIf;
        default: begin
          state_q <= StErr;
          err_q   <= 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    bus.PCWrite     = 1'b0;
    bus.PCWriteCond = 1'b0;
    bus.Branch_ne   = 1'b0;
    bus.IorD        = 1'b0;
    bus.mem_r       = 1'b0;
    bus.mem_w       = 1'b0;
    bus.IRWrite     = 1'b0;
    bus.RegDst      = 2'b00;
    bus.MemtoReg    = 2'b00;
    bus.ALUSrcA     = 1'b0;
    bus.ALUSrcB     = 2'b00;
    bus.SignExt     = 1'b0;
    bus.PCSource    = 2'b00;
    bus.RegWrite    = 1'b0;
    bus.CPU_MIO     = 1'b0;
    alu_op          = AluAnd;
    case (state_q)
      StIf: begin
        bus.mem_r   = 1'b1;
        bus.CPU_MIO = 1'b1;
        bus.ALUSrcB = 2'b01;
        alu_op      = AluAdd;
        bus.IRWrite = bus.MIO_ready;
        bus.PCWrite = bus.MIO_ready;
      end
      StId: begin
        bus.ALUSrcB = 2'b11;
        alu_op      = AluAdd;
      end
      StExR: begin
        bus.ALUSrcA = 1'b1;
        alu_op      = r_op;
      end
      StExI: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = 2'b10;
        bus.SignExt = (bus.OPcode == OpAddi) || (bus.OPcode == OpSlti);
        alu_op      = i_op;
      end
      StMemAdr: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = 2'b10;
        bus.SignExt = 1'b1;
        alu_op      = AluAdd;
      end
      StMemRd: begin
        bus.IorD    = 1'b1;
        bus.CPU_MIO = 1'b1;
        bus.mem_r   = 1'b1;
      end
      StMemWr: begin
        bus.IorD    = 1'b1;
        bus.CPU_MIO = 1'b1;
        bus.mem_w   = 1'b1;
      end
      StWbR: begin
        bus.RegDst   = 2'b01;
        bus.RegWrite = 1'b1;
      end
      StWbI: begin
        bus.RegWrite = 1'b1;
        bus.MemtoReg = (bus.OPcode == OpLui) ? 2'b11 : 2'b00;
      end
      StWbLw: begin
        bus.MemtoReg = 2'b01;
        bus.RegWrite = 1'b1;
      end
      StExBr: begin
        bus.ALUSrcA     = 1'b1;
        alu_op          = AluSub;
        bus.PCSource    = 2'b01;
        bus.PCWriteCond = 1'b1;
        bus.Branch_ne   = (bus.OPcode == OpBne);
      end
      StExJ: begin
        bus.PCSource = 2'b10;
        bus.PCWrite  = 1'b1;
        if (bus.OPcode == OpJal) begin
          bus.RegDst   = 2'b10;
          bus.MemtoReg = 2'b10;
          bus.RegWrite = 1'b1;
        end
      end
      default: ;
    endcase
    bus.ALU_Control      = '0;
    bus.ALU_Control[2:0] = alu_op;
  end

  assign bus.state = state_q;
  assign bus.err   = err_q;
endmodule

// File: tb/tb_mcpu_ctrl_fsm.sv
// Randomized self-checking bench for mcpu_ctrl_fsm against an instruction-level path model.
module tb_mcpu_ctrl_fsm;
  typedef struct packed {
    logic       pcw, pcwc, bne, iord, mr, mw, irw;
    logic [1:0] regdst, m2r;
    logic       asa;
    logic [1:0] asb;
    logic       se;
    logic [1:0] pcs;
    logic       rw;
    logic [2:0] aluc;
    logic       mio;
  } outs_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode, fun;
  logic       ready, zero;
  int         sel;
  int         n_checks = 0;
  int         n_fail = 0;

  outs_t      obs1, obs2, obs;
  logic [3:0] st_obs;
  logic       err_obs;

  mcpu_ctrl_if #(.ALUC_W(3)) bus1 ();
  mcpu_ctrl_if #(.ALUC_W(3)) bus2 ();

  assign bus1.OPcode = opcode;
  assign bus1.Fun = fun;
  assign bus1.MIO_ready = ready;
  assign bus1.zero = zero;
  assign bus2.OPcode = opcode;
  assign bus2.Fun = fun;
  assign bus2.MIO_ready = ready;
  assign bus2.zero = zero;

  mcpu_ctrl_fsm #(.ALUC_W(3), .MIO_TIMEOUT(16), .EN_IMM(1'b1), .EN_BNE(1'b1)) u_dut (
    .clk(clk), .rst(rst), .bus(bus1)
  );
  mcpu_ctrl_fsm #(.ALUC_W(3), .MIO_TIMEOUT(0), .EN_IMM(1'b0), .EN_BNE(1'b0)) u_dut_min (
    .clk(clk), .rst(rst), .bus(bus2)
  );

  always #5 clk = ~clk;

  assign obs1 = {bus1.PCWrite, bus1.PCWriteCond, bus1.Branch_ne, bus1.IorD, bus1.mem_r,
                 bus1.mem_w, bus1.IRWrite, bus1.RegDst, bus1.MemtoReg, bus1.ALUSrcA,
                 bus1.ALUSrcB, bus1.SignExt, bus1.PCSource, bus1.RegWrite, bus1.ALU_Control,
                 bus1.CPU_MIO};
  assign obs2 = {bus2.PCWrite, bus2.PCWriteCond, bus2.Branch_ne, bus2.IorD, bus2.mem_r,
                 bus2.mem_w, bus2.IRWrite, bus2.RegDst, bus2.MemtoReg, bus2.ALUSrcA,
                 bus2.ALUSrcB, bus2.SignExt, bus2.PCSource, bus2.RegWrite, bus2.ALU_Control,
                 bus2.CPU_MIO};
  assign obs     = (sel != 0) ? obs2 : obs1;
  assign st_obs  = (sel != 0) ? bus2.state : bus1.state;
  assign err_obs = (sel != 0) ? bus2.err : bus1.err;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int alu_of_fun(input logic [5:0] fn);
    case (fn)
      6'h20: return 2;
      6'h22: return 6;
      6'h24: return 0;
      6'h25: return 1;
      6'h2A: return 7;
      6'h27: return 4;
      6'h26: return 3;
      6'h02: return 5;
      default: return -1;
    endcase
  endfunction

  // Expected control word for each state, straight from the state/output table.
  function automatic outs_t exp_outs(input int st, input logic [5:0] op, input logic [5:0] fn,
                                     input logic rdy);
    outs_t o = '0;
    case (st)
      1: begin o.mr = 1; o.mio = 1; o.asb = 2'b01; o.aluc = 3'b010; o.irw = rdy; o.pcw = rdy; end
      2: begin o.asb = 2'b11; o.aluc = 3'b010; end
      3: begin o.asa = 1; o.aluc = 3'(alu_of_fun(fn)); end
      4: begin
        o.asa = 1; o.asb = 2'b10;
        o.se = (op == 6'h08) || (op == 6'h0A);
        o.aluc = (op == 6'h0A) ? 3'b111 : (op == 6'h0C) ? 3'b000 : (op == 6'h0D) ? 3'b001 : 3'b010;
      end
      5: begin o.asa = 1; o.asb = 2'b10; o.se = 1; o.aluc = 3'b010; end
      6: begin o.iord = 1; o.mio = 1; o.mr = 1; end
      7: begin o.iord = 1; o.mio = 1; o.mw = 1; end
      8: begin o.regdst = 2'b01; o.rw = 1; end
      9: begin o.rw = 1; o.m2r = (op == 6'h0F) ? 2'b11 : 2'b00; end
      10: begin o.m2r = 2'b01; o.rw = 1; end
      11: begin o.asa = 1; o.aluc = 3'b110; o.pcs = 2'b01; o.pcwc = 1; o.bne = (op == 6'h05); end
      12: begin
        o.pcs = 2'b10; o.pcw = 1;
        if (op == 6'h03) begin o.regdst = 2'b10; o.m2r = 2'b10; o.rw = 1; end
      end
      default: ;
    endcase
    return o;
  endfunction

  task automatic build_path(input logic [5:0] op, input logic [5:0] fn, input bit en_imm,
                            input bit en_bne, output int seq[5], output int len);
    seq[0] = 1; seq[1] = 2; seq[2] = 15; seq[3] = 0; seq[4] = 0; len = 3;
    case (op)
      6'h00: if (alu_of_fun(fn) >= 0) begin seq[2] = 3; seq[3] = 8; len = 4; end
      6'h23: begin seq[2] = 5; seq[3] = 6; seq[4] = 10; len = 5; end
      6'h2B: begin seq[2] = 5; seq[3] = 7; len = 4; end
      6'h04: seq[2] = 11;
      6'h05: if (en_bne) seq[2] = 11;
      6'h02, 6'h03: seq[2] = 12;
      6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0F: if (en_imm) begin seq[2] = 4; seq[3] = 9; len = 4; end
      default: ;
    endcase
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("rst_state", 32'(st_obs), 32'd0);
    check_eq("rst_outs", 32'(obs), 32'd0);
    check_eq("rst_err", 32'(err_obs), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("idle_state", 32'(st_obs), 32'd0);
    check_eq("idle_outs", 32'(obs), 32'd0);
  endtask

  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int stall_if,
                           input int stall_mem, input bit abort);
    int seq[5];
    int len, tmo, s, n;
    int exp_st[$];
    logic rdy[$];
    bit ended_err;
    outs_t eo, go;
    tmo = (sel != 0) ? 0 : 16;
    build_path(op, fn, sel == 0, sel == 0, seq, len);
    ended_err = 0;
    for (int k = 0; k < len && !ended_err; k++) begin
      s = seq[k];
      if (s == 15) begin
        ended_err = 1;
      end else if (s == 1 || s == 6 || s == 7) begin
        n = (s == 1) ? stall_if : stall_mem;
        if (tmo != 0 && n >= tmo) begin
          repeat (tmo) begin exp_st.push_back(s); rdy.push_back(1'b0); end
          ended_err = 1;
        end else begin
          repeat (n) begin exp_st.push_back(s); rdy.push_back(1'b0); end
          exp_st.push_back(s); rdy.push_back(1'b1);
        end
      end else begin
        exp_st.push_back(s); rdy.push_back(1'($urandom));
      end
    end
    if (ended_err) repeat (2) begin exp_st.push_back(15); rdy.push_back(1'($urandom)); end

    for (int i = 0; i < exp_st.size(); i++) begin
      @(negedge clk);
      opcode = op; fun = fn; ready = rdy[i]; zero = 1'($urandom);
      #1;
      eo = exp_outs(exp_st[i], op, fn, rdy[i]);
      go = obs;
      if (exp_st[i] == 4 && op == 6'h0F) begin
        eo.aluc = '0; eo.se = 1'b0; go.aluc = '0; go.se = 1'b0;
      end
      check_eq("state", 32'(st_obs), 32'(exp_st[i]));
      check_eq("outs", 32'(go), 32'(eo));
      check_eq("err", 32'(err_obs), 32'(exp_st[i] == 15));
      if (abort && exp_st[i] == 7) begin
        #2 rst = 1'b1;
        #1;
        check_eq("abort_state", 32'(st_obs), 32'd0);
        check_eq("abort_mem_w", 32'(obs.mw), 32'd0);
        check_eq("abort_outs", 32'(obs), 32'd0);
        do_reset();
        return;
      end
    end
    if (ended_err) do_reset();
  endtask

  task automatic rand_instr(input int max_stall_hi);
    logic [5:0] op, fn;
    int si, sm;
    case ($urandom_range(0, 12))
      0: op = 6'h02;  1: op = 6'h03;  2: op = 6'h04;  3: op = 6'h05;
      4: op = 6'h08;  5: op = 6'h0A;  6: op = 6'h0C;  7: op = 6'h0D;
      8: op = 6'h0F;  9: op = 6'h23;  10: op = 6'h2B; 11: op = 6'($urandom);
      default: op = 6'h00;
    endcase
    case ($urandom_range(0, 8))
      0: fn = 6'h20; 1: fn = 6'h22; 2: fn = 6'h24; 3: fn = 6'h25;
      4: fn = 6'h2A; 5: fn = 6'h27; 6: fn = 6'h26; 7: fn = 6'h02;
      default: fn = 6'($urandom);
    endcase
    si = ($urandom_range(0, 9) == 0) ? $urandom_range(14, max_stall_hi) : $urandom_range(0, 3);
    sm = ($urandom_range(0, 9) == 0) ? $urandom_range(14, max_stall_hi) : $urandom_range(0, 3);
    run_instr(op, fn, si, sm, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; opcode = '0; fun = 6'h20; ready = 1'b1; zero = 1'b0; sel = 0;
    repeat (2) @(negedge clk);
    do_reset();
    run_instr(6'h00, 6'h20, 0, 0, 1'b0);   // add: IF ID EX_R WB_R
    run_instr(6'h23, 6'h00, 0, 3, 1'b0);   // lw with 3 stalls in MEM_RD
    run_instr(6'h04, 6'h00, 0, 0, 1'b0);
    run_instr(6'h05, 6'h00, 0, 0, 1'b0);
    run_instr(6'h03, 6'h00, 0, 0, 1'b0);
    run_instr(6'h0F, 6'h00, 0, 0, 1'b0);
    run_instr(6'h00, 6'h20, 15, 0, 1'b0);  // ready arrives on the 16th IF cycle
    run_instr(6'h00, 6'h20, 16, 0, 1'b0);  // 16 stalled IF cycles: timeout
    run_instr(6'h2B, 6'h00, 0, 15, 1'b0);
    run_instr(6'h2B, 6'h00, 0, 16, 1'b0);
    run_instr(6'h2B, 6'h00, 1, 3, 1'b1);   // reset aborts MEM_WR
    run_instr(6'h3F, 6'h00, 0, 0, 1'b0);
    run_instr(6'h00, 6'h3F, 0, 0, 1'b0);
    for (int i = 0; i < 150; i++) rand_instr(17);

    sel = 1;
    do_reset();
    run_instr(6'h05, 6'h00, 0, 0, 1'b0);   // bne disabled
    run_instr(6'h08, 6'h00, 0, 0, 1'b0);   // imm ops disabled
    run_instr(6'h04, 6'h00, 20, 0, 1'b0);  // no timeout when disabled
    run_instr(6'h23, 6'h00, 2, 20, 1'b0);
    for (int i = 0; i < 60; i++) rand_instr(20);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
